// File: rtl/branch_sequencer.sv
// branch_sequencer
//   Multi-cycle branch control unit for the 64-bit LEGv8 datapath. Takes one
//   branch-class instruction (B, BL, BR, B.cond, CBZ, CBNZ) per start
//   handshake, walks it through IDLE/EVAL/LINK/JUMP and drives the 31-bit
//   datapath control word plus the sign-extended branch constant K.
//
// Ports
//   clock        single clock, all state changes on the rising edge
//   reset        synchronous, active-high
//   start        instruction valid, only looked at in IDLE
//   instruction  32-bit instruction word, valid with start
//   status       {V, C, Z, N, ZI}; ZI is the zero flag of the live ALU result
//   controlword  {Psel[1:0], DA, SA, SB, Fsel, regW, ramW, EN_MEM, EN_ALU,
//                 EN_B, EN_PC, Bsel, PCsel, SL}
//   K            sign-extended word offset, held until the next acceptance
//   busy         state is not IDLE
//   done         one-cycle pulse in the JUMP cycle
//   taken        valid with done: PC leaves the sequential path
//   illegal      one-cycle pulse after accepting a non-branch word
module branch_sequencer #(
  parameter int         DATA_WIDTH = 64,
  parameter logic [4:0] LINK_REG   = 5'd30,
  parameter logic [4:0] PASS_FSEL  = 5'b00100
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           instruction,
  input  logic [4:0]            status,
  output logic [30:0]           controlword,
  output logic [DATA_WIDTH-1:0] K,
  output logic                  busy,
  output logic                  done,
  output logic                  taken,
  output logic                  illegal
);

  typedef enum logic [1:0] {ST_IDLE, ST_EVAL, ST_LINK, ST_JUMP} state_t;
  // CBZ and CBNZ share one class; instruction bit 24 tells them apart.
  typedef enum logic [2:0] {OP_NONE, OP_B, OP_BL, OP_BR, OP_BCOND, OP_CB} op_t;

  state_t                  state_reg, state_next;
  op_t                     op_reg, dec_op;
  logic [DATA_WIDTH-1:0]   k_reg, dec_k;
  logic [9:0]              fld_reg;     // instruction[9:0]: Rt, Rn, cond
  logic                    nz_reg;      // instruction[24]: 1 for CBNZ
  logic                    zi_reg;
  logic                    illegal_reg;
  logic                    accept;

  logic [1:0]  psel;
  logic [4:0]  da, sa, sb, fsel;
  logic        regw, en_alu, en_pc, pcsel, done_c;

  // Condition evaluation: each even code is a base test, the odd code that
  // follows it is its inverse, except 1111 which is always true like 1110.
  logic        v_f, c_f, z_f, n_f;
  logic [7:0]  cond_base;
  logic [15:0] cond_vec;

  assign v_f = status[4];
  assign c_f = status[3];
  assign z_f = status[2];
  assign n_f = status[1];
  assign cond_base = {1'b1, ~z_f & (n_f == v_f), (n_f == v_f), c_f & ~z_f,
                      v_f, n_f, c_f, z_f};

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_cond
      assign cond_vec[2*gi] = cond_base[gi];
      if (gi == 7) begin : g_always
        assign cond_vec[2*gi+1] = 1'b1;
      end else begin : g_inv
        assign cond_vec[2*gi+1] = ~cond_base[gi];
      end
    end
  endgenerate

  assign accept = (state_reg == ST_IDLE) && start;

  // Opcode class and branch constant of the word currently on the input.
  always_comb begin
    dec_op = OP_NONE;
    dec_k  = '0;
    if (instruction[31:26] == 6'b000101) begin
      dec_op = OP_B;
      dec_k  = {{(DATA_WIDTH-26){instruction[25]}}, instruction[25:0]};
    end else if (instruction[31:26] == 6'b100101) begin
      dec_op = OP_BL;
      dec_k  = {{(DATA_WIDTH-26){instruction[25]}}, instruction[25:0]};
    end else if (instruction[31:25] == 7'b1011010) begin
      dec_op = OP_CB;
      dec_k  = {{(DATA_WIDTH-19){instruction[23]}}, instruction[23:5]};
    end else if (instruction[31:24] == 8'b01010100) begin
      dec_op = OP_BCOND;
      dec_k  = {{(DATA_WIDTH-19){instruction[23]}}, instruction[23:5]};
    end else if (instruction[31:21] == 11'b11010110000) begin
      dec_op = OP_BR;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      op_reg      <= OP_NONE;
      k_reg       <= '0;
      fld_reg     <= '0;
      nz_reg      <= 1'b0;
      zi_reg      <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      illegal_reg <= accept && (dec_op == OP_NONE);
      if (accept) begin
        op_reg  <= dec_op;
        k_reg   <= dec_k;
        fld_reg <= instruction[9:0];
        nz_reg  <= instruction[24];
      end
      if (state_reg == ST_EVAL) begin
        zi_reg <= status[0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    psel   = 2'b00;
    da     = 5'd31;
    sa     = 5'd31;
    sb     = 5'd31;
    fsel   = 5'd0;
    regw   = 1'b0;
    en_alu = 1'b0;
    en_pc  = 1'b0;
    pcsel  = 1'b0;
    done_c = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          case (dec_op)
            OP_B, OP_BR, OP_BCOND: state_next = ST_JUMP;
            OP_BL:                 state_next = ST_LINK;
            OP_CB:                 state_next = ST_EVAL;
            default:               state_next = ST_IDLE;
          endcase
        end
      end
      ST_EVAL: begin
        // Pass Rt through the ALU so ZI reflects Rt == 0.
        sa         = fld_reg[4:0];
        fsel       = PASS_FSEL;
        en_alu     = 1'b1;
        state_next = ST_JUMP;
      end
      ST_LINK: begin
        // PC+4 is on the bus via EN_PC and lands in the link register.
        da         = LINK_REG;
        regw       = 1'b1;
        en_pc      = 1'b1;
        state_next = ST_JUMP;
      end
      ST_JUMP: begin
        pcsel      = 1'b1;
        done_c     = 1'b1;
        state_next = ST_IDLE;
        case (op_reg)
          OP_B, OP_BL: psel = 2'b11;
          OP_BR: begin
            sa   = fld_reg[9:5];
            psel = 2'b10;
          end
          OP_CB:    psel = {zi_reg ^ nz_reg, 1'b1};
          OP_BCOND: psel = {cond_vec[fld_reg[3:0]], 1'b1};
          default:  psel = 2'b00;
        endcase
      end
      default: state_next = ST_IDLE;
    endcase
    // While reset is held the word is forced to NOP so an in-flight link
    // write or PC update never reaches the datapath.
    if (reset) begin
      psel   = 2'b00;
      da     = 5'd31;
      sa     = 5'd31;
      fsel   = 5'd0;
      regw   = 1'b0;
      en_alu = 1'b0;
      en_pc  = 1'b0;
      pcsel  = 1'b0;
      done_c = 1'b0;
    end
  end

  assign controlword = {psel, da, sa, sb, fsel, regw, 1'b0, 1'b0, en_alu,
                        1'b0, en_pc, 1'b0, pcsel, 1'b0};
  assign K       = k_reg;
  assign busy    = (state_reg != ST_IDLE);
  assign done    = done_c;
  assign taken   = done_c & psel[1];
  assign illegal = illegal_reg;

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Multi-cycle branch control unit for the 64-bit LEGv8 datapath, the parametrised successor of the single-cycle conditional-branch decoder. Accepts one branch-class instruction per `start` handshake (B, BL, BR, B.cond, CBZ, CBNZ), sequences it through a small FSM, and drives the standard 31-bit control word plus a sign-extended branch constant `K`. Sits beside the other instruction-class decoders; its control word is muxed onto the datapath while `busy` is high.

## Interface
- `DATA_WIDTH`, 64: width of `K` and of the datapath.
- `LINK_REG`, 5'd30: destination register written by BL.
- `PASS_FSEL`, 5'b00100: ALU function that passes A to the result with a valid zero flag.

- `clock`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  instruction valid; sampled only in IDLE.
- `instruction`  in  32  instruction word, valid with `start`.
- `status`  in  5  {V, C, Z, N, ZI}; V/C/Z/N from status register, ZI = zero of current ALU result.
- `controlword`  out  31  {Psel[1:0], DA[4:0], SA[4:0], SB[4:0], Fsel[4:0], regW, ramW, EN_MEM, EN_ALU, EN_B, EN_PC, Bsel, PCsel, SL}.
- `K`  out  DATA_WIDTH  sign-extended word offset.
- `busy`  out  1  high when state ≠ IDLE.
- `done`  out  1  one-cycle pulse in final (JUMP) cycle.
- `taken`  out  1  valid with `done`: PC leaves the sequential path.
- `illegal`  out  1  one-cycle pulse: accepted word is not a branch.

## Operation
- Decode (on accepted `start`): B `[31:26]=000101`; BL `100101`; CBZ `[31:24]=10110100`; CBNZ `10110101`; B.cond `01010100`, cond=`[3:0]`; BR `[31:21]=11010110000`, Rn=`[9:5]`. Instruction, opcode class and K latched into registers.
- K: B/BL sign-extend `[25:0]`; CBZ/CBNZ/B.cond sign-extend `[23:5]`; BR 0. Held until next acceptance.
- Psel encoding: 00 hold PC, 01 PC+4, 11 PC+4+4·K, 10 PC←A bus.
- States: IDLE, EVAL, LINK, JUMP.
  - IDLE: NOP word (Psel=00, DA=SA=SB=31, all else 0). On `start`: B/BR/B.cond → JUMP; BL → LINK; CBZ/CBNZ → EVAL; other → stay IDLE, pulse `illegal` next cycle.
  - EVAL: SA=Rt `[4:0]`, SB=31, Fsel=PASS_FSEL, EN_ALU=1, Psel=00, regW=0, SL=0. `status[0]` registered into `zi_q` at end of cycle. → JUMP.
  - LINK: DA=LINK_REG, regW=1, EN_PC=1 (PC+4 on bus), Psel=00. → JUMP.
  - JUMP: PCsel=1, regW=ramW=SL=0, `done`=1. B/BL Psel=11; BR SA=Rn, Psel=10; CBZ/CBNZ Psel={zi_q ^ instr[24], 1}; B.cond Psel={cond_true, 1}. → IDLE.
- cond_true from live V/C/Z/N: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL/1111 1.
- `taken` = Psel[1] in JUMP; 0 elsewhere.
- Status is never updated (SL=0 in every state).

## Timing
- Reset: state IDLE; controlword NOP; K=0; zi_q=0; busy/done/taken/illegal=0.
- Reset mid-instruction: next edge returns to IDLE, no PC update, no `done`; a pending LINK write is dropped if reset precedes its edge.
- Latency (start at cycle t): B/BR/B.cond `done` at t+1; BL/CBZ/CBNZ `done` at t+2. Next `start` accepted at IDLE (t+2 or t+3). Illegal: `illegal` at t+1, `busy` stays 0.
- `start` while `busy` ignored, no queueing. `instruction` sampled only with accepted `start`.
- controlword combinational from state + latched registers + `status`; no cycle has regW and PCsel both high.

## Test plan
- Reset, then B `0x14000010` -> t+1: done=1, taken=1, Psel=11, K=0x10; t+2: busy=0, NOP word.
- BL imm26=`0x3FFFFFF` -> LINK: DA=30, regW=1, EN_PC=1; JUMP: Psel=11, K=64'hFFFF_FFFF_FFFF_FFFF.
- CBZ Rt=3 with ZI=1 in EVAL -> JUMP Psel=11, taken=1; CBNZ same ZI -> Psel=01, taken=0; ZI changed during JUMP has no effect.
- B.cond GT with {V,C,Z,N}=0000 -> Psel=11; with N=1,V=0 -> Psel=01; AL always 11.
- BR X5 -> t+1: SA=5, Psel=10, taken=1; `start` at t+1 ignored.
- ADD word with start -> illegal pulse at t+1, busy=0; reset asserted in LINK of BL -> next cycle IDLE, done never pulses.
